// File: rtl/ecc_scrub_ctrl_if.sv
// Memory-port bundle shared between the ECC scrubber (master) and the
// memory arbiter (slave): request/grant handshake plus read-return channel.
interface ecc_scrub_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int SYND_W = 7
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [SYND_W-1:0] mem_wchk;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [SYND_W-1:0] mem_rchk;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rchk
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rchk
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber. Walks addresses 0..DEPTH-1, reads each word with
// its check bits, hands it to the external syndrome/location decoder and
// writes back the corrected word when exactly one data bit is in error.
// Corrected and uncorrectable events are counted with saturating counters.
// Optional macro ECC_SCRUB_ERRLOG_EN adds err_valid/err_addr, which capture
// the first uncorrectable address of a pass.
module ecc_scrub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int SYND_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    ecc_scrub_ctrl_if.master  mem,
    output logic [DATA_W-1:0] dec_data,
    output logic [SYND_W-1:0] dec_chk,
    input  logic [SYND_W-1:0] dec_synd,
    input  logic [DATA_W-1:0] dec_loc,
    input  logic [SYND_W-1:0] chk_in,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`ifdef ECC_SCRUB_ERRLOG_EN
    ,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CHECK   = 3'd3,
        WR_REQ  = 3'd4,
        NEXT    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SYND_W-1:0] wchk;
    logic              req;
    logic              we;
    logic              synd_nz;
    logic              loc_single;
    logic              last_addr;

    // A location vector is correctable only if it names exactly one bit.
    function automatic logic is_single(input logic [DATA_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign synd_nz    = (dec_synd != '0);
    assign loc_single = is_single(dec_loc);
    assign last_addr  = (addr == LAST_ADDR);

    assign busy          = (state != IDLE);
    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
    assign mem.mem_wchk  = wchk;

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and the handshake strobes driven by each state.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        we        = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RD_REQ;
            RD_REQ: begin
                req = 1'b1;
                if (mem.mem_gnt) state_nxt = RD_WAIT;
            end
            RD_WAIT: if (mem.mem_rvalid) state_nxt = CHECK;
            CHECK: begin
                if (synd_nz && loc_single) state_nxt = WR_REQ;
                else                       state_nxt = NEXT;
            end
            WR_REQ: begin
                req = 1'b1;
                we  = 1'b1;
                if (mem.mem_gnt) state_nxt = NEXT;
            end
            NEXT: begin
                if (last_addr) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RD_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address walk, word capture, correction and event bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            wdata      <= '0;
            wchk       <= '0;
            dec_data   <= '0;
            dec_chk    <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
`ifdef ECC_SCRUB_ERRLOG_EN
            err_valid  <= 1'b0;
            err_addr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr       <= '0;
                        corr_cnt   <= '0;
                        uncorr_cnt <= '0;
`ifdef ECC_SCRUB_ERRLOG_EN
                        err_valid  <= 1'b0;
                        err_addr   <= '0;
`endif
                    end
                end
                RD_WAIT: begin
                    if (mem.mem_rvalid) begin
                        dec_data <= mem.mem_rdata;
                        dec_chk  <= mem.mem_rchk;
                    end
                end
                CHECK: begin
                    if (synd_nz) begin
                        if (loc_single) begin
                            wdata    <= dec_data ^ dec_loc;
                            wchk     <= chk_in;
                            corr_cnt <= sat_inc(corr_cnt);
                        end else begin
                            uncorr_cnt <= sat_inc(uncorr_cnt);
`ifdef ECC_SCRUB_ERRLOG_EN
                            if (!err_valid) begin
                                err_valid <= 1'b1;
                                err_addr  <= addr;
                            end
`endif
                        end
                    end
                end
                NEXT: begin
                    if (!last_addr) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: bench-side memory, arbiter and
// decoder stub, a pass-level reference model and a per-cycle monitor.
`timescale 1ns/1ps
module tb_ecc_scrub_ctrl;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;
    localparam int DATA_W = 32;
    localparam int SYND_W = 7;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic [DATA_W-1:0] dec_data, dec_loc;
    logic [SYND_W-1:0] dec_chk, dec_synd, chk_in;
    logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
`ifdef ECC_SCRUB_ERRLOG_EN
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;
`endif

    ecc_scrub_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYND_W(SYND_W)) mif();

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
                     .SYND_W(SYND_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem(mif),
        .dec_data(dec_data), .dec_chk(dec_chk), .dec_synd(dec_synd),
        .dec_loc(dec_loc), .chk_in(chk_in),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`ifdef ECC_SCRUB_ERRLOG_EN
        , .err_valid(err_valid), .err_addr(err_addr)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- bench memory, arbiter and decoder stub -------------
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [SYND_W-1:0] mem_c   [DEPTH];
    logic [DATA_W-1:0] loc_tab [128];

    function automatic logic [SYND_W-1:0] fold(input logic [31:0] d);
        return d[6:0] ^ d[13:7] ^ d[20:14] ^ d[27:21] ^ {3'b000, d[31:28]};
    endfunction

    // Toy code: syndrome = stored check bits xor fold(data); location from a table.
    always_comb begin
        dec_synd = dec_chk ^ fold(dec_data);
        dec_loc  = loc_tab[dec_synd];
        chk_in   = fold(dec_data ^ dec_loc);
    end

    int gnt_mode = 0;   // 0 always, 1 random, 2 five-cycle stall per request, 3 reads only
    bit rand_dly = 0;
    int hold     = 0;
    int rd_cnt   = 0;
    int rd_a     = 0;

    initial begin
        bit g;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        mif.mem_rchk   = '0;
        forever begin
            @(negedge clk);
            mif.mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = mem_d[rd_a];
                    mif.mem_rchk   = mem_c[rd_a];
                end
            end
            case (gnt_mode)
                0:       g = 1'b1;
                1:       g = 1'($urandom_range(0, 1));
                2:       g = (hold >= 5);
                default: g = !mif.mem_we;
            endcase
            mif.mem_gnt = g;
            if (mif.mem_req) begin
                if (g) hold = 0;
                else   hold++;
            end
            if (mif.mem_req && g) begin
                if (mif.mem_we) begin
                    mem_d[int'(mif.mem_addr)] = mif.mem_wdata;
                    mem_c[int'(mif.mem_addr)] = mif.mem_wchk;
                end else begin
                    rd_a   = int'(mif.mem_addr);
                    rd_cnt = 1 + (rand_dly ? int'($urandom_range(0, 2)) : 0);
                end
            end
        end
    end

    // ---------------- pass-level reference model --------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [6:0]        c;
    } wr_t;

    wr_t               exp_q[$];
    int                exp_corr, exp_uncorr;
    logic              exp_err_v;
    logic [ADDR_W-1:0] exp_err_a;
    bit                model_on = 0;

    task automatic model_pass();
        int corr = 0;
        int unc  = 0;
        logic [6:0]  s;
        logic [31:0] l;
        exp_q.delete();
        exp_err_v = 1'b0;
        exp_err_a = '0;
        for (int a = 0; a < DEPTH; a++) begin
            s = mem_c[a] ^ fold(mem_d[a]);
            if (s != 7'd0) begin
                l = loc_tab[s];
                if ($countones(l) == 1) begin
                    exp_q.push_back('{a: ADDR_W'(a), d: mem_d[a] ^ l, c: fold(mem_d[a] ^ l)});
                    corr++;
                end else begin
                    if (!exp_err_v) begin
                        exp_err_v = 1'b1;
                        exp_err_a = ADDR_W'(a);
                    end
                    unc++;
                end
            end
        end
        exp_corr   = (corr > CMAX) ? CMAX : corr;
        exp_uncorr = (unc  > CMAX) ? CMAX : unc;
    endtask

    // ---------------- per-cycle monitor ------------------------------------
    int                wr_seen   = 0;
    int                done_seen = 0;
    logic [ADDR_W-1:0] last_wa;
    logic [31:0]       last_wd;
    logic [6:0]        last_wc;

    initial begin
        logic              p_req, p_gnt, p_we, p_rst;
        logic [ADDR_W-1:0] p_addr;
        logic [31:0]       p_wd;
        wr_t               e;
        p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0; p_rst = 1'b1;
        p_addr = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (p_req && !p_gnt && !p_rst) begin
                    chk("hold_req",  64'(mif.mem_req),  64'(1'b1));
                    chk("hold_we",   64'(mif.mem_we),   64'(p_we));
                    chk("hold_addr", 64'(mif.mem_addr), 64'(p_addr));
                    chk("hold_wdata", 64'(mif.mem_wdata), 64'(p_wd));
                end
                if (!busy) chk("req_when_idle", 64'(mif.mem_req), 64'(1'b0));
                if (mif.mem_req && mif.mem_gnt && mif.mem_we) begin
                    wr_seen++;
                    last_wa = mif.mem_addr;
                    last_wd = mif.mem_wdata;
                    last_wc = mif.mem_wchk;
                    if (model_on) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write_addr", 64'(mif.mem_addr), 64'hFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", 64'(mif.mem_addr),  64'(e.a));
                            chk("wr_data", 64'(mif.mem_wdata), 64'(e.d));
                            chk("wr_chk",  64'(mif.mem_wchk),  64'(e.c));
                        end
                    end
                end
                if (done) begin
                    done_seen++;
                    if (model_on) begin
                        chk("corr_cnt",   64'(corr_cnt),   64'(exp_corr));
                        chk("uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
                        chk("writes_left", 64'(exp_q.size()), 64'(0));
`ifdef ECC_SCRUB_ERRLOG_EN
                        chk("err_valid", 64'(err_valid), 64'(exp_err_v));
                        if (exp_err_v) chk("err_addr", 64'(err_addr), 64'(exp_err_a));
`endif
                    end
                end
            end
            p_req  = mif.mem_req;
            p_gnt  = mif.mem_gnt;
            p_we   = mif.mem_we;
            p_addr = mif.mem_addr;
            p_wd   = mif.mem_wdata;
            p_rst  = rst;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic clean_mem();
        for (int s = 0; s < 128; s++) loc_tab[s] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = $urandom;
            mem_c[a] = fold(mem_d[a]);
        end
    endtask

    task automatic random_mem();
        int s;
        for (int i = 0; i < 128; i++) begin
            case ($urandom_range(0, 3))
                0:       loc_tab[i] = 32'h1 << $urandom_range(0, 31);
                1:       loc_tab[i] = '0;
                2:       loc_tab[i] = 32'hF;
                default: loc_tab[i] = $urandom;
            endcase
        end
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = $urandom;
            s = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 127));
            mem_c[a] = fold(mem_d[a]) ^ 7'(s);
        end
    endtask

    // Launch a pass and return the start-to-done latency in cycles.
    task automatic run_pass(input bit mid_start, input bit check_clear, output int lat);
        model_pass();
        model_on = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        if (check_clear) begin
            chk("clear_corr",   64'(corr_cnt),   64'(0));
            chk("clear_uncorr", 64'(uncorr_cnt), 64'(0));
        end
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
            start = mid_start && (lat == 10);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        int lat, w0, d0;
        rst = 1'b1;
        start = 1'b0;
        clean_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy),          64'(0));
        chk("rst_done",   64'(done),          64'(0));
        chk("rst_req",    64'(mif.mem_req),   64'(0));
        chk("rst_we",     64'(mif.mem_we),    64'(0));
        chk("rst_addr",   64'(mif.mem_addr),  64'(0));
        chk("rst_wdata",  64'(mif.mem_wdata), 64'(0));
        chk("rst_wchk",   64'(mif.mem_wchk),  64'(0));
        chk("rst_ddata",  64'(dec_data),      64'(0));
        chk("rst_dchk",   64'(dec_chk),       64'(0));
        chk("rst_corr",   64'(corr_cnt),      64'(0));
        chk("rst_uncorr", 64'(uncorr_cnt),    64'(0));
`ifdef ECC_SCRUB_ERRLOG_EN
        chk("rst_errv",   64'(err_valid),     64'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        // All clean: 4 cycles per word, no writes.
        gnt_mode = 0; rand_dly = 0;
        w0 = wr_seen; d0 = done_seen;
        run_pass(0, 0, lat);
        chk("clean_latency", 64'(lat), 64'(4 * DEPTH));
        chk("clean_writes", 64'(wr_seen - w0), 64'(0));
        chk("clean_corr",   64'(corr_cnt),     64'(0));
        chk("clean_uncorr", 64'(uncorr_cnt),   64'(0));
        chk("clean_dones",  64'(done_seen - d0), 64'(1));

        // Word 2 = 1, syndrome 97 points at bit 0.
        clean_mem();
        mem_d[2] = 32'h0000_0001; mem_c[2] = 7'd96; loc_tab[97] = 32'h0000_0001;
        w0 = wr_seen;
        run_pass(0, 0, lat);
        chk("corr_latency", 64'(lat), 64'(4 * DEPTH + 1));
        chk("corr_writes",  64'(wr_seen - w0), 64'(1));
        chk("corr_waddr",   64'(last_wa), 64'(2));
        chk("corr_wdata",   64'(last_wd), 64'(0));
        chk("corr_wchk",    64'(last_wc), 64'(0));
        chk("corr_count",   64'(corr_cnt), 64'(1));

        // Word 1 with syndrome 0x3F and the 4-bit flag location.
        clean_mem();
        mem_d[1] = 32'h1234_5678; mem_c[1] = fold(32'h1234_5678) ^ 7'h3F; loc_tab[7'h3F] = 32'hF;
        w0 = wr_seen;
        run_pass(0, 0, lat);
        chk("unc_writes", 64'(wr_seen - w0), 64'(0));
        chk("unc_count",  64'(uncorr_cnt),   64'(1));
`ifdef ECC_SCRUB_ERRLOG_EN
        chk("unc_errv", 64'(err_valid), 64'(1));
        chk("unc_erra", 64'(err_addr),  64'(1));
`endif

        // Five stall cycles on every request (six reads, one write).
        clean_mem();
        mem_d[2] = 32'h0000_0001; mem_c[2] = 7'd96; loc_tab[97] = 32'h0000_0001;
        gnt_mode = 2; hold = 0;
        w0 = wr_seen;
        run_pass(0, 0, lat);
        chk("stall_latency", 64'(lat), 64'(4 * DEPTH + 1 + 5 * (DEPTH + 1)));
        chk("stall_writes",  64'(wr_seen - w0), 64'(1));
        chk("stall_wdata",   64'(last_wd), 64'(0));

        // Reset while the write is waiting for its grant.
        clean_mem();
        mem_d[2] = 32'h0000_0001; mem_c[2] = 7'd96; loc_tab[97] = 32'h0000_0001;
        gnt_mode = 3;
        w0 = wr_seen;
        model_pass();
        model_on = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!(mif.mem_req && mif.mem_we) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("reach_wr_req", 64'(mif.mem_req && mif.mem_we), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   64'(busy),        64'(0));
        chk("abort_req",    64'(mif.mem_req), 64'(0));
        chk("abort_corr",   64'(corr_cnt),    64'(0));
        chk("abort_uncorr", 64'(uncorr_cnt),  64'(0));
        rst = 1'b0;
        model_on = 0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("abort_writes", 64'(wr_seen - w0), 64'(0));
        chk("abort_idle",   64'(busy),         64'(0));

        // All words correctable: counter saturates, mid-pass start ignored.
        clean_mem();
        for (int a = 0; a < DEPTH; a++) begin
            mem_c[a] = fold(mem_d[a]) ^ 7'(a + 1);
            loc_tab[a + 1] = 32'h1 << $urandom_range(0, 31);
        end
        gnt_mode = 0;
        d0 = done_seen;
        run_pass(1, 0, lat);
        chk("sat_latency", 64'(lat), 64'(4 * DEPTH + DEPTH));
        chk("sat_corr",    64'(corr_cnt), 64'(CMAX));
        chk("sat_dones",   64'(done_seen - d0), 64'(1));
        repeat (3) @(negedge clk);
        chk("sat_hold",    64'(corr_cnt), 64'(CMAX));
        run_pass(0, 1, lat);
        chk("second_corr", 64'(corr_cnt), 64'(0));

        // Randomized passes against the model.
        for (int p = 0; p < 25; p++) begin
            random_mem();
            gnt_mode = int'($urandom_range(0, 1));
            rand_dly = 1;
            d0 = done_seen;
            run_pass(0, 0, lat);
            chk("rand_dones", 64'(done_seen - d0), 64'(1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        model_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
